// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared state encoding and address constants for pc_sequencer
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DSLOT = 2'd2
    } pc_state_t;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_0180;

    // Low address bits cleared on every PC load to keep fetches word aligned.
    localparam logic [1:0]  WORD_ALIGN    = 2'b11;

endpackage

// File: rtl/pc_redirect_latch.sv
// rtl/pc_redirect_latch.sv - one-entry pending redirect target register
module pc_redirect_latch #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_set,
    input  logic [WIDTH-1:0] i_target,
    input  logic             i_consume,
    input  logic             i_flush,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_target
);

    logic             r_valid;
    logic [WIDTH-1:0] r_target;

    // First captured target is kept until it is consumed or flushed.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_valid  <= 1'b0;
            r_target <= '0;
        end else if (i_consume) begin
            r_valid  <= 1'b0;
        end else if (i_set && !r_valid) begin
            r_valid  <= 1'b1;
            r_target <= i_target;
        end
    end

    assign o_valid  = r_valid;
    assign o_target = r_target;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - MIPS fetch PC register, next-PC select and I-memory request FSM
// Optional branch-delay-slot behaviour is enabled with macro DELAY_SLOT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_imem_ready,
    input  logic             i_stall,
    input  logic             i_branch_taken,
    input  logic [WIDTH-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_exc,
    output logic [WIDTH-1:0] o_pc,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_epc,
    output logic             o_exc_bd
);

    localparam logic [WIDTH-1:0] W_MASK = ~{{(WIDTH-2){1'b0}}, WORD_ALIGN};

    pc_state_t        r_state, w_next_state;
    logic [WIDTH-1:0] r_pc, w_next_pc;
    logic [WIDTH-1:0] r_epc;
    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_redir_tgt;
    logic             w_redir_in;
    logic             w_advance;
    logic             w_set, w_consume, w_flush;
    logic             w_pend_valid;
    logic [WIDTH-1:0] w_pend_tgt;

    assign w_pc_plus4  = r_pc + WIDTH'(4);
    assign w_redir_in  = i_jump | i_branch_taken;
    assign w_redir_tgt = (i_jump ? i_jump_target : i_branch_target) & W_MASK;
    assign w_advance   = (r_state != ST_IDLE) && i_imem_ready && !i_stall;

    pc_redirect_latch #(.WIDTH(WIDTH)) u_redirect_latch (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_set     (w_set),
        .i_target  (w_redir_tgt),
        .i_consume (w_consume),
        .i_flush   (w_flush),
        .o_valid   (w_pend_valid),
        .o_target  (w_pend_tgt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_VEC & W_MASK;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_set        = 1'b0;
        w_consume    = 1'b0;
        w_flush      = 1'b0;
        if (i_exc) begin
            w_next_pc    = EXC_VEC & W_MASK;
            w_next_state = ST_FETCH;
            w_flush      = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_FETCH;
                    w_set        = w_redir_in;
                end
                ST_FETCH: begin
                    if (!w_advance) begin
                        w_set = w_redir_in;
                    end else begin
`ifdef DELAY_SLOT_EN
                        // Fetch the slot first; the target waits in the latch.
                        w_next_pc = w_pc_plus4;
                        if (w_pend_valid || w_redir_in) begin
                            w_next_state = ST_DSLOT;
                            w_set        = w_redir_in;
                        end
`else
                        if (w_pend_valid) begin
                            w_next_pc = w_pend_tgt;
                            w_consume = 1'b1;
                        end else if (w_redir_in) begin
                            w_next_pc = w_redir_tgt;
                        end else begin
                            w_next_pc = w_pc_plus4;
                        end
`endif
                    end
                end
`ifdef DELAY_SLOT_EN
                ST_DSLOT: begin
                    if (w_advance) begin
                        w_next_pc    = w_pend_tgt;
                        w_consume    = 1'b1;
                        w_next_state = ST_FETCH;
                    end
                end
`endif
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

`ifdef DELAY_SLOT_EN
    logic r_exc_bd;

    // In the slot the faulting context belongs to the branch one word back.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_epc    <= '0;
            r_exc_bd <= 1'b0;
        end else if (i_exc) begin
            r_epc    <= (r_state == ST_DSLOT) ? (r_pc - WIDTH'(4)) : r_pc;
            r_exc_bd <= (r_state == ST_DSLOT);
        end
    end

    assign o_exc_bd = r_exc_bd;
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_epc <= '0;
        end else if (i_exc) begin
            r_epc <= r_pc;
        end
    end

    assign o_exc_bd = 1'b0;
`endif

    assign o_pc       = r_pc;
    assign o_epc      = r_epc;
    assign o_imem_req = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exc;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] epc;
    logic        exc_bd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_imem_ready    (imem_ready),
        .i_stall         (stall),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .i_jump          (jump),
        .i_jump_target   (jump_target),
        .i_exc           (exc),
        .o_pc            (pc),
        .o_imem_req      (imem_req),
        .o_epc           (epc),
        .o_exc_bd        (exc_bd)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ready = 1'b1; stall = 1'b0; exc = 1'b0;
        branch_taken = 1'b0; branch_target = '0;
        jump = 1'b0; jump_target = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h500; exc = 1'b1;
        step(); step();
        n_tests++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || epc !== 32'h0 || exc_bd !== 1'b0) begin
            $display("FAIL reset pc=%h req=%b epc=%h bd=%b exp pc=0 req=0 epc=0 bd=0", pc, imem_req, epc, exc_bd);
            n_fail++;
        end
        clear_inputs();
        rst = 1'b0;
        #2;
        n_tests++;
        if (imem_req !== 1'b0) begin
            $display("FAIL idle_req req=%b exp=0", imem_req);
            n_fail++;
        end
        step();
        n_tests++;
        if (imem_req !== 1'b1 || pc !== 32'h0) begin
            $display("FAIL fetch_entry req=%b pc=%h exp req=1 pc=0", imem_req, pc);
            n_fail++;
        end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 2; i++) begin
            step();
            n_tests++;
            if (pc !== 32'(i * 4)) begin
                $display("FAIL seq_step%0d pc=%h exp=%h", i, pc, 32'(i * 4));
                n_fail++;
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_tests++;
            if (pc !== 32'h8) begin
                $display("FAIL stall_hold%0d pc=%h exp=00000008", i, pc);
                n_fail++;
            end
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (pc !== 32'hC) begin
            $display("FAIL stall_resume pc=%h exp=0000000c", pc);
            n_fail++;
        end
        imem_ready = 1'b0;
        step(); step();
        n_tests++;
        if (pc !== 32'hC) begin
            $display("FAIL notready_hold pc=%h exp=0000000c", pc);
            n_fail++;
        end
        imem_ready = 1'b1;
        step();
        n_tests++;
        if (pc !== 32'h10) begin
            $display("FAIL ready_resume pc=%h exp=00000010", pc);
            n_fail++;
        end
    endtask

    task automatic test_pending_redirect();
        stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h40;
        step();
        branch_target = 32'h80;
        step();
        branch_taken = 1'b0;
        step();
        n_tests++;
        if (pc !== 32'h10) begin
            $display("FAIL redirect_stall_hold pc=%h exp=00000010", pc);
            n_fail++;
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (pc !== 32'h40) begin
            $display("FAIL redirect_first_wins pc=%h exp=00000040", pc);
            n_fail++;
        end
        step();
        n_tests++;
        if (pc !== 32'h44) begin
            $display("FAIL redirect_consumed pc=%h exp=00000044", pc);
            n_fail++;
        end
        stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h500;
        step();
        branch_taken = 1'b0;
        stall = 1'b0;
        jump = 1'b1; jump_target = 32'h600;
        step();
        jump = 1'b0;
        n_tests++;
        if (pc !== 32'h500) begin
            $display("FAIL pending_over_jump pc=%h exp=00000500", pc);
            n_fail++;
        end
    endtask

    task automatic test_exception();
        jump = 1'b1; jump_target = 32'h24;
        step();
        jump = 1'b0;
        n_tests++;
        if (pc !== 32'h24) begin
            $display("FAIL jump_latency pc=%h exp=00000024", pc);
            n_fail++;
        end
        stall = 1'b1;
        branch_taken = 1'b1; branch_target = 32'h60;
        step();
        branch_taken = 1'b0;
        exc = 1'b1;
        step();
        exc = 1'b0;
        n_tests++;
        if (pc !== 32'h180 || epc !== 32'h24 || exc_bd !== 1'b0) begin
            $display("FAIL exc_take pc=%h epc=%h bd=%b exp pc=180 epc=24 bd=0", pc, epc, exc_bd);
            n_fail++;
        end
        stall = 1'b0;
        step();
        n_tests++;
        if (pc !== 32'h184) begin
            $display("FAIL exc_flush_pending pc=%h exp=00000184", pc);
            n_fail++;
        end
    endtask

    task automatic test_boundaries();
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        jump = 1'b0;
        step();
        n_tests++;
        if (pc !== 32'h0) begin
            $display("FAIL pc_wrap pc=%h exp=00000000", pc);
            n_fail++;
        end
        branch_taken = 1'b1; branch_target = 32'h43;
        step();
        branch_taken = 1'b0;
        n_tests++;
        if (pc !== 32'h40) begin
            $display("FAIL target_align pc=%h exp=00000040", pc);
            n_fail++;
        end
        jump = 1'b1; jump_target = 32'h200;
        branch_taken = 1'b1; branch_target = 32'h300;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        n_tests++;
        if (pc !== 32'h200) begin
            $display("FAIL jump_over_branch pc=%h exp=00000200", pc);
            n_fail++;
        end
    endtask

    task automatic test_exc_in_idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        exc = 1'b1;
        step();
        exc = 1'b0;
        n_tests++;
        if (pc !== 32'h180 || imem_req !== 1'b1 || epc !== 32'h0) begin
            $display("FAIL exc_idle pc=%h req=%b epc=%h exp pc=180 req=1 epc=0", pc, imem_req, epc);
            n_fail++;
        end
    endtask

    task automatic test_delay_slot();
        for (int i = 0; i < 8; i++) step();
        n_tests++;
        if (pc !== 32'h20) begin
            $display("FAIL ds_reach pc=%h exp=00000020", pc);
            n_fail++;
        end
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        n_tests++;
        if (pc !== 32'h24) begin
            $display("FAIL ds_slot pc=%h exp=00000024", pc);
            n_fail++;
        end
        step();
        n_tests++;
        if (pc !== 32'h100) begin
            $display("FAIL ds_target pc=%h exp=00000100", pc);
            n_fail++;
        end
        jump = 1'b1; jump_target = 32'h20;
        step();
        jump = 1'b0;
        step();
        branch_taken = 1'b1; branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        exc = 1'b1;
        step();
        exc = 1'b0;
        n_tests++;
        if (pc !== 32'h180 || epc !== 32'h20 || exc_bd !== 1'b1) begin
            $display("FAIL ds_exc pc=%h epc=%h bd=%b exp pc=180 epc=20 bd=1", pc, epc, exc_bd);
            n_fail++;
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
`ifdef DELAY_SLOT_EN
        test_delay_slot();
`else
        test_sequential();
        test_stall();
        test_pending_redirect();
        test_exception();
        test_boundaries();
        test_exc_in_idle();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
